matrix_load_ctrl: RTL and testbench



---
 rtl/matrix_load_ctrl.sv | 138 +++++++++++++
 tb/tb_matrix_load_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_load_ctrl.sv
// matrix_load_ctrl: packs a stream of DATA_W-bit words into one A word and one
// B word, writes each into the core's port-B memories, then starts the core
// and waits for Done (bounded by TIMEOUT) before accepting the next pair.
module matrix_load_ctrl #(
  parameter int DATA_W  = 32,
  parameter int WORDS   = 4,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [DATA_W-1:0]         In_Data,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  output logic [DATA_W*WORDS-1:0]   MA_dib,
  output logic [ADDR_W-1:0]         MA_Addrb,
  output logic                      MA_enb,
  output logic                      MA_web,
  output logic [DATA_W*WORDS-1:0]   MB_dib,
  output logic [ADDR_W-1:0]         MB_Addrb,
  output logic                      MB_enb,
  output logic                      MB_web,
  output logic                      Rst_Core,
  output logic                      Go,
  input  logic                      Done,
  output logic                      Busy,
  output logic                      Load_Done,
  output logic                      Err
);

  localparam int PACK_W = DATA_W * WORDS;
  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FILL_A,
    WR_A,
    FILL_B,
    WR_B,
    GO,
    WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    word_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [PACK_W-1:0]   pack_q;
  logic [PACK_W-1:0]   ma_dib_q, mb_dib_q;
  logic                rst_core_q, load_done_q, err_q;

  logic                accept, last_word, timeout_hit;
  logic [PACK_W-1:0]   packed_next;

  // First accepted word ends up in the top slice: shift left, new word at the bottom.
  assign packed_next = {pack_q[PACK_W-DATA_W-1:0], In_Data};
  assign accept      = In_Valid & In_Ready;
  assign last_word   = (word_cnt_q == CNT_W'(WORDS - 1));
  assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

  // Output decode from registered state; In_Ready is held low during reset.
  always_comb begin
    In_Ready  = Rst_n & ((state_q == FILL_A) | (state_q == FILL_B));
    MA_enb    = (state_q == WR_A);
    MA_web    = (state_q == WR_A);
    MB_enb    = (state_q == WR_B);
    MB_web    = (state_q == WR_B);
    Go        = (state_q == GO);
    Busy      = (state_q != FILL_A);
    MA_Addrb  = '0;
    MB_Addrb  = '0;
    MA_dib    = ma_dib_q;
    MB_dib    = mb_dib_q;
    Rst_Core  = rst_core_q;
    Load_Done = load_done_q;
    Err       = err_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL_A: if (accept && last_word) state_d = WR_A;
      WR_A:   state_d = FILL_B;
      FILL_B: if (accept && last_word) state_d = WR_B;
      WR_B:   state_d = GO;
      GO:     state_d = WAIT;
      WAIT:   if (Done || timeout_hit) state_d = FILL_A;
      default: state_d = FILL_A;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= FILL_A;
    else        state_q <= state_d;
  end

  // Packing, counters, core reset, completion pulse and sticky error.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      word_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      pack_q      <= '0;
      ma_dib_q    <= '0;
      mb_dib_q    <= '0;
      rst_core_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      load_done_q <= (state_q == WAIT) && Done;

      if (accept) begin
        pack_q <= packed_next;
        if (last_word) begin
          word_cnt_q <= '0;
          if (state_q == FILL_A) ma_dib_q <= packed_next;
          else                   mb_dib_q <= packed_next;
        end else begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
      end

      if (state_q == WR_B) rst_core_q <= 1'b0;

      if (state_q == GO) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT && !Done) begin
        if (timeout_hit) begin
          err_q      <= 1'b1;
          rst_core_q <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Directed bench for matrix_load_ctrl: basic and throttled loads, timeout,
// spurious Done and reset in the middle of a fill.
module tb_matrix_load_ctrl;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [31:0]  In_Data;
  logic         In_Valid;
  logic         In_Ready;
  logic [127:0] MA_dib, MB_dib;
  logic [0:0]   MA_Addrb, MB_Addrb;
  logic         MA_enb, MA_web, MB_enb, MB_web;
  logic         Rst_Core, Go, Done, Busy, Load_Done, Err;

  int checks   = 0;
  int failures = 0;

  int           wr_a_cnt = 0, wr_b_cnt = 0, go_cnt = 0;
  logic [127:0] wr_a_val = '0, wr_b_val = '0;
  int           a0, b0, g0;

  always #5 Clk = ~Clk;

  matrix_load_ctrl #(
    .DATA_W (32),
    .WORDS  (4),
    .ADDR_W (1),
    .TIMEOUT(8)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .MA_dib   (MA_dib),
    .MA_Addrb (MA_Addrb),
    .MA_enb   (MA_enb),
    .MA_web   (MA_web),
    .MB_dib   (MB_dib),
    .MB_Addrb (MB_Addrb),
    .MB_enb   (MB_enb),
    .MB_web   (MB_web),
    .Rst_Core (Rst_Core),
    .Go       (Go),
    .Done     (Done),
    .Busy     (Busy),
    .Load_Done(Load_Done),
    .Err      (Err)
  );

  // Record memory writes and start pulses as seen at each rising edge.
  always @(posedge Clk) begin
    if (MA_enb && MA_web) begin
      wr_a_cnt <= wr_a_cnt + 1;
      wr_a_val <= MA_dib;
    end
    if (MB_enb && MB_web) begin
      wr_b_cnt <= wr_b_cnt + 1;
      wr_b_val <= MB_dib;
    end
    if (Go) go_cnt <= go_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] d, input bit throttle);
    bit took = 1'b0;
    In_Data  = d;
    In_Valid = 1'b1;
    for (int k = 0; k < 40 && !took; k++) begin
      if (In_Ready) took = 1'b1;
      step();
    end
    check("word_accepted", {127'd0, took}, 128'd1);
    if (throttle) begin
      In_Valid = 1'b0;
      step();
    end
  endtask

  task automatic send_four(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input bit throttle);
    send_word(w0, throttle);
    send_word(w1, throttle);
    send_word(w2, throttle);
    send_word(w3, throttle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; In_Valid = 1'b0; In_Data = '0; Done = 1'b0;
    step(); step();

    // Reset state
    check("rst_in_ready",  {127'd0, In_Ready},  128'd0);
    check("rst_rst_core",  {127'd0, Rst_Core},  128'd1);
    check("rst_go",        {127'd0, Go},        128'd0);
    check("rst_busy",      {127'd0, Busy},      128'd0);
    check("rst_load_done", {127'd0, Load_Done}, 128'd0);
    check("rst_err",       {127'd0, Err},       128'd0);
    check("rst_en",        {124'd0, MA_enb, MA_web, MB_enb, MB_web}, 128'd0);
    check("rst_ma_dib",    MA_dib, 128'd0);
    check("rst_mb_dib",    MB_dib, 128'd0);
    check("rst_addr",      {126'd0, MA_Addrb, MB_Addrb}, 128'd0);
    Rst_n = 1'b1;
    #1;
    check("rst_rel_ready", {127'd0, In_Ready}, 128'd1);

    // Basic A/B load
    send_four(32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
    In_Valid = 1'b0;
    check("basic_ma_en",   {126'd0, MA_enb, MA_web}, 128'd3);
    check("basic_ma_dib",  MA_dib, 128'h00000001_00000002_00000003_00000004);
    check("basic_wra_rdy", {127'd0, In_Ready}, 128'd0);
    check("basic_wra_busy",{127'd0, Busy}, 128'd1);
    step();
    check("basic_ma_en_off", {127'd0, MA_enb}, 128'd0);
    check("basic_fillb_rdy", {127'd0, In_Ready}, 128'd1);
    send_four(32'h5, 32'h6, 32'h7, 32'h8, 1'b0);
    In_Valid = 1'b0;
    check("basic_mb_en",   {126'd0, MB_enb, MB_web}, 128'd3);
    check("basic_mb_dib",  MB_dib, 128'h00000005_00000006_00000007_00000008);
    check("basic_go_early",{127'd0, Go}, 128'd0);
    check("basic_rstc_pre",{127'd0, Rst_Core}, 128'd1);
    step();
    check("basic_go",      {127'd0, Go}, 128'd1);
    check("basic_rst_core",{127'd0, Rst_Core}, 128'd0);
    check("basic_mb_off",  {127'd0, MB_enb}, 128'd0);
    step();
    check("basic_go_off",  {127'd0, Go}, 128'd0);
    check("basic_wait_busy",{127'd0, Busy}, 128'd1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("basic_load_done",{127'd0, Load_Done}, 128'd1);
    check("basic_idle_busy",{127'd0, Busy}, 128'd0);
    check("basic_idle_rdy", {127'd0, In_Ready}, 128'd1);
    step();
    check("basic_ld_pulse", {127'd0, Load_Done}, 128'd0);
    check("basic_wr_counts",{64'd0, wr_a_cnt[31:0], wr_b_cnt[31:0]}, {64'd0, 32'd1, 32'd1});
    check("basic_go_count", {96'd0, go_cnt[31:0]}, 128'd1);

    // Throttled input
    a0 = wr_a_cnt; b0 = wr_b_cnt; g0 = go_cnt;
    send_four(32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
    send_four(32'h5, 32'h6, 32'h7, 32'h8, 1'b1);
    check("thr_go",        {127'd0, Go}, 128'd1);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("thr_load_done", {127'd0, Load_Done}, 128'd1);
    check("thr_wr_a_val",  wr_a_val, 128'h00000001_00000002_00000003_00000004);
    check("thr_wr_b_val",  wr_b_val, 128'h00000005_00000006_00000007_00000008);
    check("thr_wr_count",  {96'd0, 32'(wr_a_cnt - a0 + wr_b_cnt - b0)}, 128'd2);
    check("thr_go_count",  {96'd0, 32'(go_cnt - g0)}, 128'd1);

    // Timeout with Done held low
    g0 = go_cnt;
    send_four(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
    send_four(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 1'b0);
    In_Valid = 1'b0;
    step();
    check("to_go",         {127'd0, Go}, 128'd1);
    for (int i = 0; i < 8; i++) step();
    check("to_err_early",  {127'd0, Err}, 128'd0);
    check("to_busy_wait",  {127'd0, Busy}, 128'd1);
    check("to_rstc_wait",  {127'd0, Rst_Core}, 128'd0);
    step();
    check("to_err",        {127'd0, Err}, 128'd1);
    check("to_rst_core",   {127'd0, Rst_Core}, 128'd1);
    check("to_fill_a",     {126'd0, Busy, In_Ready}, 128'd1);
    check("to_no_ld",      {127'd0, Load_Done}, 128'd0);
    check("to_go_count",   {96'd0, 32'(go_cnt - g0)}, 128'd1);

    // Second load after timeout
    send_four(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 1'b0);
    send_four(32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003, 1'b0);
    In_Valid = 1'b0;
    step();
    check("re_go",         {127'd0, Go}, 128'd1);
    check("re_rst_core",   {127'd0, Rst_Core}, 128'd0);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("re_load_done",  {127'd0, Load_Done}, 128'd1);
    check("re_err_sticky", {127'd0, Err}, 128'd1);
    check("re_ma_dib",     MA_dib, 128'hA0000000_A0000001_A0000002_A0000003);
    check("re_mb_dib",     MB_dib, 128'hB0000000_B0000001_B0000002_B0000003);

    // Spurious Done while filling A
    Done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sp_no_ld",    {127'd0, Load_Done}, 128'd0);
      check("sp_state",    {126'd0, Busy, In_Ready}, 128'd1);
    end
    Done = 1'b0;

    // Reset in the middle of an A fill
    send_word(32'hDEAD0001, 1'b0);
    send_word(32'hDEAD0002, 1'b0);
    In_Data = 32'hDEAD0003;
    a0 = wr_a_cnt;
    Rst_n = 1'b0;
    step(); step();
    check("mr_ready",      {127'd0, In_Ready}, 128'd0);
    check("mr_ma_dib",     MA_dib, 128'd0);
    check("mr_err_clr",    {127'd0, Err}, 128'd0);
    check("mr_rst_core",   {127'd0, Rst_Core}, 128'd1);
    Rst_n = 1'b1;
    In_Valid = 1'b0;
    #1;
    check("mr_no_write",   {96'd0, 32'(wr_a_cnt - a0)}, 128'd0);
    send_four(32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003, 1'b0);
    In_Valid = 1'b0;
    check("mr_ma_en",      {127'd0, MA_enb}, 128'd1);
    check("mr_ma_dib_new", MA_dib, 128'hC0000000_C0000001_C0000002_C0000003);
    check("mr_write_once", {96'd0, 32'(wr_a_cnt - a0)}, 128'd0);
    step();
    check("mr_write_done", {96'd0, 32'(wr_a_cnt - a0)}, 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
